parallel_to_serial_mux: RTL



---
 rtl/parallel_to_serial_mux.sv | 110 +++++++++++
 1 files changed

// File: rtl/parallel_to_serial_mux.sv
// Word-to-bit serializer: accepts a W-bit word over valid/ready and emits it one bit per cycle.
// Bit order is LSB-first by default; define PARALLEL_TO_SERIAL_MSB_FIRST_EN for MSB-first.
module parallel_to_serial_mux #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [W-1:0] up_data,
   output logic         down_valid,
   input  logic         down_ready,
   output logic         down_data,
   output logic         down_last
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state_reg, state_next;
   logic [W-1:0]  word_reg, word_next;
   logic [IW-1:0] idx_reg, idx_next;
   logic [W-1:0]  ordered_word;
   logic          at_last;
   logic          word_accept;

   // Reorder the stored word once so the select index always walks upward.
   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_order
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
         assign ordered_word[gi] = word_reg[W-1-gi];
`else
         assign ordered_word[gi] = word_reg[gi];
`endif
      end
   endgenerate

   assign at_last = (idx_reg == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         word_reg  <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         word_reg  <= word_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      word_next   = word_reg;
      idx_next    = idx_reg;
      up_ready    = 1'b0;
      down_valid  = 1'b0;
      down_data   = 1'b0;
      down_last   = 1'b0;
      word_accept = 1'b0;

      case (state_reg)
         IDLE: begin
            up_ready    = !rst;
            word_accept = up_valid && up_ready;
            if (word_accept) begin
               word_next  = up_data;
               idx_next   = '0;
               state_next = SHIFT;
            end
         end

         SHIFT: begin
            down_valid  = 1'b1;
            down_data   = ordered_word[idx_reg];
            down_last   = at_last;
            // The next word may only enter on the cycle the final bit leaves.
            up_ready    = !rst && at_last && down_ready;
            word_accept = up_valid && up_ready;
            if (down_ready) begin
               if (!at_last) begin
                  idx_next = idx_reg + IW'(1);
               end else if (word_accept) begin
                  word_next = up_data;
                  idx_next  = '0;
               end else begin
                  idx_next   = '0;
                  state_next = IDLE;
               end
            end
         end

         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   // Stream invariants: index bounded, and a stalled bit holds until taken.
   a_idx_bound : assert property (@(posedge clk) disable iff (rst) idx_reg <= LAST_IDX);
   a_stall_hold : assert property (@(posedge clk) disable iff (rst)
      (down_valid && !down_ready) |=> (down_valid && $stable(idx_reg) && $stable(word_reg)));

endmodule
